lcd_init_seq: RTL

- Power-up initialisation sequencer for the SPI LCD. Sits directly upstream of the byte serialiser (SPI command sender) and drives it.
- Steps through a fixed internal table of command/data bytes. For each byte it presents the byte, its D/C level and its post-byte delay flag, pulses the write strobe, then waits for the sender's done pulse before moving on.
- Drives the LCD D/C pin directly and flags completion or a stalled sender.

---
 rtl/lcd_init_seq_if.sv | 34 +++
 rtl/lcd_init_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/lcd_init_seq_if.sv
// rtl/lcd_init_seq_if.sv - handshake bundle around the LCD power-up init sequencer
// Purpose : groups the start/done handshake and the sender-facing outputs of
//           lcd_init_seq so they travel as one port.
// Signals : i_start      start/restart request into the sequencer
//           i_cmd_done   one-cycle done pulse from the SPI command sender
//           o_cmd        byte presented to the sender
//           o_we         one-cycle write strobe to the sender
//           o_need_delay selects the sender's long post-byte delay
//           o_dc         LCD D/C pin (0 = command, 1 = data)
//           o_busy       sequence in progress
//           o_init_done  full table sent successfully (level)
//           o_err        sender timed out (level)
// Modports: master = sequencer side, slave = controller/sender side.
interface lcd_init_seq_if;
  logic       i_start;
  logic       i_cmd_done;
  logic [7:0] o_cmd;
  logic       o_we;
  logic       o_need_delay;
  logic       o_dc;
  logic       o_busy;
  logic       o_init_done;
  logic       o_err;

  modport master (
    input  i_start, i_cmd_done,
    output o_cmd, o_we, o_need_delay, o_dc, o_busy, o_init_done, o_err
  );

  modport slave (
    output i_start, i_cmd_done,
    input  o_cmd, o_we, o_need_delay, o_dc, o_busy, o_init_done, o_err
  );
endinterface

// File: rtl/lcd_init_seq.sv
// rtl/lcd_init_seq.sv - power-up initialisation sequencer driving the SPI LCD command sender
// Purpose : walks a fixed table of {need_delay, dc, byte} entries, presenting
//           each to the sender with a one-cycle write strobe and waiting for
//           its done pulse; flags completion or a stalled sender.
// Ports   : i_clk    system clock
//           i_rst_n  asynchronous active-low reset
//           bus      lcd_init_seq_if.master (start/done in, byte/strobe/D-C/status out)
// All bus outputs are registered.
module lcd_init_seq #(
  parameter int N_ENTRIES = 7,
  parameter int TIMEOUT   = 3_000_000,
  parameter int TMO_W     = 22
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  lcd_init_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [3:0]       LAST_IDX = 4'(N_ENTRIES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [3:0]       idx, idx_nx;
  logic [TMO_W-1:0] tmo_cnt, tmo_nx;

  logic [7:0] cmd_nx;
  logic       we_nx, nd_nx, dc_nx, busy_nx, init_done_nx, err_nx;
  logic [9:0] ent;

  // {need_delay, dc, byte}
  function automatic logic [9:0] table_entry(input logic [3:0] i);
    case (i)
      4'd0:    return {1'b1, 1'b0, 8'h01};  // software reset
      4'd1:    return {1'b1, 1'b0, 8'h11};  // sleep out
      4'd2:    return {1'b0, 1'b0, 8'h3A};  // pixel format
      4'd3:    return {1'b0, 1'b1, 8'h55};
      4'd4:    return {1'b0, 1'b0, 8'h36};  // memory access control
      4'd5:    return {1'b0, 1'b1, 8'h48};
      4'd6:    return {1'b0, 1'b0, 8'h29};  // display on
      default: return 10'h000;
    endcase
  endfunction

  // State, index, timeout counter and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= S_IDLE;
      idx              <= '0;
      tmo_cnt          <= '0;
      bus.o_cmd        <= 8'h00;
      bus.o_we         <= 1'b0;
      bus.o_need_delay <= 1'b0;
      bus.o_dc         <= 1'b0;
      bus.o_busy       <= 1'b0;
      bus.o_init_done  <= 1'b0;
      bus.o_err        <= 1'b0;
    end else begin
      state            <= state_nx;
      idx              <= idx_nx;
      tmo_cnt          <= tmo_nx;
      bus.o_cmd        <= cmd_nx;
      bus.o_we         <= we_nx;
      bus.o_need_delay <= nd_nx;
      bus.o_dc         <= dc_nx;
      bus.o_busy       <= busy_nx;
      bus.o_init_done  <= init_done_nx;
      bus.o_err        <= err_nx;
    end
  end

  // Next state / index / counter. Done is tested before the timeout so a
  // done pulse on the final counted cycle still completes the entry.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    tmo_nx   = tmo_cnt;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.i_start) begin
          state_nx = S_ISSUE;
          idx_nx   = '0;
        end
      end
      S_ISSUE: begin
        state_nx = S_WAIT;
        tmo_nx   = '0;
      end
      S_WAIT: begin
        if (bus.i_cmd_done) begin
          if (idx == LAST_IDX) begin
            state_nx = S_DONE;
          end else begin
            idx_nx   = idx + 4'd1;
            state_nx = S_ISSUE;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx = S_ERR;
        end else begin
          tmo_nx = tmo_cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered outputs. Every transition into ISSUE
  // (start or advance) loads the new entry, so the byte/D-C/delay lines
  // are already valid in the strobe cycle and stay put through WAIT.
  always_comb begin
    ent          = table_entry(idx_nx);
    cmd_nx       = bus.o_cmd;
    nd_nx        = bus.o_need_delay;
    dc_nx        = bus.o_dc;
    busy_nx      = bus.o_busy;
    init_done_nx = bus.o_init_done;
    err_nx       = bus.o_err;
    we_nx        = (state_nx == S_ISSUE);
    if (state_nx == S_ISSUE) begin
      cmd_nx       = ent[7:0];
      dc_nx        = ent[8];
      nd_nx        = ent[9];
      busy_nx      = 1'b1;
      init_done_nx = 1'b0;
      err_nx       = 1'b0;
    end else if (state == S_WAIT && state_nx == S_DONE) begin
      busy_nx      = 1'b0;
      init_done_nx = 1'b1;
    end else if (state == S_WAIT && state_nx == S_ERR) begin
      busy_nx = 1'b0;
      err_nx  = 1'b1;
    end
  end

endmodule
